// File: rtl/core_rvfi_csr_diff_if.sv
// CSR snapshot bundle carried from the core's CSR trace tap.
interface core_rvfi_csr_trace #(
  parameter int XLEN = 64
);
  logic [XLEN-1:0] mstatus, misa, medeleg, mideleg, mie, mtvec;
  logic [XLEN-1:0] mscratch, mepc, mcause, mtval, mip;
  logic [XLEN-1:0] mvendorid, marchid, mimpid, mhartid;
  logic [XLEN-1:0] cycle, mtime, instret, mcountin;

  modport I (
    input mstatus, misa, medeleg, mideleg, mie, mtvec,
          mscratch, mepc, mcause, mtval, mip,
          mvendorid, marchid, mimpid, mhartid,
          cycle, mtime, instret, mcountin
  );
  modport O (
    output mstatus, misa, medeleg, mideleg, mie, mtvec,
           mscratch, mepc, mcause, mtval, mip,
           mvendorid, marchid, mimpid, mhartid,
           cycle, mtime, instret, mcountin
  );
endinterface

// File: rtl/core_rvfi_csr_diff.sv
// CSR change tracer: turns per-retire CSR snapshots into a serial stream of
// (addr, old, new, order) records, one per tracked CSR that changed.

// One CSR lane: holds the committed baseline and the snapshot of the
// accepted retire, and flags a tracked difference against the live input.
module core_rvfi_csr_diff_lane #(
  parameter int XLEN  = 64,
  parameter bit TRACK = 1'b1
) (
  input  logic            clk_i,
  input  logic            prime_i,
  input  logic            snap_ld_i,
  input  logic            commit_i,
  input  logic [XLEN-1:0] csr_i,
  output logic [XLEN-1:0] base_o,
  output logic [XLEN-1:0] snap_o,
  output logic            diff_o
);
  logic [XLEN-1:0] base_q, snap_q;

  // Data-only storage; contents are irrelevant until PRIME has loaded base.
  always_ff @(posedge clk_i) begin
    if (prime_i)       base_q <= csr_i;
    else if (commit_i) base_q <= snap_q;
    if (snap_ld_i)     snap_q <= csr_i;
  end

  assign base_o = base_q;
  assign snap_o = snap_q;
  // Full-width compare; untracked lanes never report, so never commit.
  assign diff_o = TRACK && (csr_i != base_q);
endmodule

module core_rvfi_csr_diff #(
  parameter int          XLEN      = 64,
  parameter logic [18:0] DIFF_MASK = 19'h47FFF
) (
  input  logic              g_clk,
  input  logic              g_reset,
  core_rvfi_csr_trace.I     csr,
  input  logic              retire_valid,
  input  logic [63:0]       retire_order,
  output logic              busy,
  output logic              overflow,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [11:0]       trace_addr,
  output logic [XLEN-1:0]   trace_old,
  output logic [XLEN-1:0]   trace_new,
  output logic [63:0]       trace_order,
  output logic              trace_last
);
  localparam int NCSR = 19;

  typedef enum logic [1:0] {S_PRIME, S_IDLE, S_SCAN} state_e;

  state_e state_q, state_d;

  logic [NCSR-1:0][XLEN-1:0] csr_vec, base, snap;
  logic [NCSR-1:0]           diff;
  logic [NCSR-1:0]           pend_q, pend_d, pend_oh, scan_rem;
  logic [NCSR-1:0]           cand, cand_oh;
  logic [4:0]                cand_k;
  logic                      cand_last;
  logic [XLEN-1:0]           cand_old, cand_new;
  logic [63:0]               order_q, order_d;
  logic                      ovf_q, ovf_d;
  logic                      tv_q, tv_d, tl_q, tl_d;
  logic [11:0]               ta_q, ta_d;
  logic [XLEN-1:0]           to_q, to_d, tn_q, tn_d;
  logic [63:0]               tord_q, tord_d;
  logic                      prime, accept, hs;

  // Index of the lowest set bit; records drain in ascending index order.
  function automatic logic [4:0] lowest(input logic [NCSR-1:0] v);
    lowest = '0;
    for (int i = NCSR - 1; i >= 0; i--) if (v[i]) lowest = 5'(i);
  endfunction

  function automatic logic [11:0] csr_addr(input logic [4:0] k);
    case (k)
      5'd0:    csr_addr = 12'h300;
      5'd1:    csr_addr = 12'h301;
      5'd2:    csr_addr = 12'h302;
      5'd3:    csr_addr = 12'h303;
      5'd4:    csr_addr = 12'h304;
      5'd5:    csr_addr = 12'h305;
      5'd6:    csr_addr = 12'h340;
      5'd7:    csr_addr = 12'h341;
      5'd8:    csr_addr = 12'h342;
      5'd9:    csr_addr = 12'h343;
      5'd10:   csr_addr = 12'h344;
      5'd11:   csr_addr = 12'hF11;
      5'd12:   csr_addr = 12'hF12;
      5'd13:   csr_addr = 12'hF13;
      5'd14:   csr_addr = 12'hF14;
      5'd15:   csr_addr = 12'hC00;
      5'd16:   csr_addr = 12'hC01;
      5'd17:   csr_addr = 12'hC02;
      5'd18:   csr_addr = 12'h320;
      default: csr_addr = 12'h000;
    endcase
  endfunction

  assign csr_vec[0]  = csr.mstatus;
  assign csr_vec[1]  = csr.misa;
  assign csr_vec[2]  = csr.medeleg;
  assign csr_vec[3]  = csr.mideleg;
  assign csr_vec[4]  = csr.mie;
  assign csr_vec[5]  = csr.mtvec;
  assign csr_vec[6]  = csr.mscratch;
  assign csr_vec[7]  = csr.mepc;
  assign csr_vec[8]  = csr.mcause;
  assign csr_vec[9]  = csr.mtval;
  assign csr_vec[10] = csr.mip;
  assign csr_vec[11] = csr.mvendorid;
  assign csr_vec[12] = csr.marchid;
  assign csr_vec[13] = csr.mimpid;
  assign csr_vec[14] = csr.mhartid;
  assign csr_vec[15] = csr.cycle;
  assign csr_vec[16] = csr.mtime;
  assign csr_vec[17] = csr.instret;
  assign csr_vec[18] = csr.mcountin;

  assign prime  = (state_q == S_PRIME);
  assign accept = (state_q == S_IDLE) && retire_valid;
  assign hs     = (state_q == S_SCAN) && tv_q && trace_ready;

  // The record on the bus is always the lowest pending index.
  assign pend_oh  = pend_q & (~pend_q + 1'b1);
  assign scan_rem = pend_q & ~pend_oh;

  genvar g;
  generate
    for (g = 0; g < NCSR; g++) begin : g_lane
      core_rvfi_csr_diff_lane #(
        .XLEN  (XLEN),
        .TRACK (DIFF_MASK[g])
      ) u_lane (
        .clk_i     (g_clk),
        .prime_i   (prime),
        .snap_ld_i (accept),
        .commit_i  (hs && pend_oh[g]),
        .csr_i     (csr_vec[g]),
        .base_o    (base[g]),
        .snap_o    (snap[g]),
        .diff_o    (diff[g])
      );
    end
  endgenerate

  // Next record candidate: fresh diff on accept, remaining pend after a handshake.
  // Its new value comes from the live CSRs on accept since snap loads on the same edge.
  always_comb begin
    cand      = (state_q == S_IDLE) ? diff : scan_rem;
    cand_oh   = cand & (~cand + 1'b1);
    cand_k    = lowest(cand);
    cand_last = ((cand & ~cand_oh) == '0);
    cand_old  = base[cand_k];
    cand_new  = (state_q == S_IDLE) ? csr_vec[cand_k] : snap[cand_k];
  end

  // Next-state, pend bookkeeping and registered record load.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    order_d = order_q;
    ovf_d   = ovf_q;
    tv_d    = tv_q;
    tl_d    = tl_q;
    ta_d    = ta_q;
    to_d    = to_q;
    tn_d    = tn_q;
    tord_d  = tord_q;
    busy    = 1'b1;
    case (state_q)
      S_PRIME: begin
        state_d = S_IDLE;
        if (retire_valid) ovf_d = 1'b1;
      end
      S_IDLE: begin
        busy = 1'b0;
        if (retire_valid) begin
          pend_d  = cand;
          order_d = retire_order;
          if (cand != '0) begin
            state_d = S_SCAN;
            tv_d    = 1'b1;
            ta_d    = csr_addr(cand_k);
            to_d    = cand_old;
            tn_d    = cand_new;
            tl_d    = cand_last;
            tord_d  = retire_order;
          end
        end
      end
      S_SCAN: begin
        if (retire_valid) ovf_d = 1'b1;
        if (hs) begin
          pend_d = scan_rem;
          if (scan_rem == '0) begin
            state_d = S_IDLE;
            tv_d    = 1'b0;
          end else begin
            ta_d = csr_addr(cand_k);
            to_d = cand_old;
            tn_d = cand_new;
            tl_d = cand_last;
          end
        end
      end
      default: state_d = S_PRIME;
    endcase
  end

  // Control and record registers, cleared asynchronously.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q <= S_PRIME;
      pend_q  <= '0;
      order_q <= '0;
      ovf_q   <= 1'b0;
      tv_q    <= 1'b0;
      tl_q    <= 1'b0;
      ta_q    <= '0;
      to_q    <= '0;
      tn_q    <= '0;
      tord_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      order_q <= order_d;
      ovf_q   <= ovf_d;
      tv_q    <= tv_d;
      tl_q    <= tl_d;
      ta_q    <= ta_d;
      to_q    <= to_d;
      tn_q    <= tn_d;
      tord_q  <= tord_d;
    end
  end

  assign overflow    = ovf_q;
  assign trace_valid = tv_q;
  assign trace_addr  = ta_q;
  assign trace_old   = to_q;
  assign trace_new   = tn_q;
  assign trace_order = tord_q;
  assign trace_last  = tl_q;
endmodule
